// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath: pixel width, kernel size and the
// packed-window element ordering used by both the window generator and the
// 3x3 convolution stage.
package cnn_pkg;

  localparam int DATA_W = 16;
  localparam int KSIZE  = 3;
  localparam int WIN_W  = DATA_W * KSIZE * KSIZE;

  // Element index inside a packed window: row 0 is the oldest image row,
  // col 0 the leftmost column, so index 0 is top-left and the last index is
  // the most recent pixel.
  function automatic int win_idx(input int row, input int col);
    return row * KSIZE + col;
  endfunction

endpackage

// File: rtl/line_fifo.sv
// Fixed-delay line buffer: every enabled push returns the value pushed DEPTH
// pushes earlier. Built as a circular RAM with a single wrap pointer and a
// registered read that prefetches the slot the next push will overwrite.
module line_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  logic [WIDTH-1:0] dout_reg;

  // Next slot, wrapping at DEPTH-1.
  always_comb begin
    ptr_next = ptr_reg + 1'b1;
    if (ptr_reg == PTR_W'(DEPTH - 1)) begin
      ptr_next = '0;
    end
  end

  // Wrap pointer advances only on an accepted push.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (en) begin
      ptr_reg <= ptr_next;
    end
  end

  // RAM write plus prefetch of the slot the next push will replace. That slot
  // is never the one written this cycle (DEPTH >= 3), so the read returns the
  // old contents. Contents are deliberately not cleared on reset.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr_reg] <= din;
      dout_reg     <= mem[ptr_next];
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 sliding-window generator. Two line buffers hold the previous
// two image rows; a 3x3 shift register assembles the neighbourhood and a full
// window is emitted only when it lies entirely inside the current frame.
module window_gen_3x3
  import cnn_pkg::KSIZE;
  import cnn_pkg::win_idx;
#(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            out_valid,
  output logic [KSIZE*KSIZE*DATA_W-1:0]   window,
  output logic                            out_last
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic             col_end;
  logic             row_end;
  logic             emit;
  logic             emit_last;

  logic [DATA_W-1:0] lf0_out;
  logic [DATA_W-1:0] lf1_out;
  logic [DATA_W-1:0] new_col  [KSIZE];
  logic [DATA_W-1:0] win_reg  [KSIZE][KSIZE];
  logic [DATA_W-1:0] win_next [KSIZE][KSIZE];
  logic [KSIZE*KSIZE*DATA_W-1:0] window_next;

  logic                          out_valid_reg;
  logic                          out_last_reg;
  logic [KSIZE*KSIZE*DATA_W-1:0] window_reg;

  assign col_end   = (col_reg == COL_W'(IMG_W - 1));
  assign row_end   = (row_reg == ROW_W'(IMG_H - 1));
  // Only windows whose three columns and three rows all belong to the current
  // row band of this frame are emitted; row-straddling windows are dropped.
  assign emit      = in_valid && (row_reg >= ROW_W'(2)) && (col_reg >= COL_W'(2));
  assign emit_last = emit && row_end && col_end;

  // Raster position of the next pixel; wraps to (0,0) after the frame's last pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (in_valid) begin
      if (col_end) begin
        col_reg <= '0;
        row_reg <= row_end ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // lf1 delays the incoming stream by one row, lf0 by a second row.
  line_fifo #(.WIDTH(DATA_W), .DEPTH(IMG_W)) u_lf1 (
    .clk  (clk),
    .rst  (rst),
    .en   (in_valid),
    .din  (in_data),
    .dout (lf1_out)
  );

  line_fifo #(.WIDTH(DATA_W), .DEPTH(IMG_W)) u_lf0 (
    .clk  (clk),
    .rst  (rst),
    .en   (in_valid),
    .din  (lf1_out),
    .dout (lf0_out)
  );

  // Incoming column, oldest row on top.
  assign new_col[0] = lf0_out;
  assign new_col[1] = lf1_out;
  assign new_col[2] = in_data;

  // Each row shifts left by one; the new column enters on the right. The
  // packed form of the shifted array is exactly the window to emit.
  for (genvar gi = 0; gi < KSIZE; gi++) begin : g_row
    for (genvar gj = 0; gj < KSIZE; gj++) begin : g_col
      if (gj == KSIZE - 1) begin : g_new
        assign win_next[gi][gj] = new_col[gi];
      end else begin : g_shift
        assign win_next[gi][gj] = win_reg[gi][gj+1];
      end
      assign window_next[DATA_W*win_idx(gi, gj) +: DATA_W] = win_next[gi][gj];
    end
  end

  // Neighbourhood shift register; moves only on accepted pixels.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      win_reg <= win_next;
    end
  end

  // Registered outputs; window only changes when a new window is emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      window_reg    <= '0;
    end else begin
      out_valid_reg <= emit;
      out_last_reg  <= emit_last;
      if (emit) begin
        window_reg <= window_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign window    = window_reg;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3: a 4x4 instance for the hand-computed
// scenarios and a 28x28 instance checked against a 3x3 extraction of random data.
module tb_window_gen_3x3;

  localparam int DW = 16;
  localparam int WW = 9 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          v4, v28;
  logic [DW-1:0] d4, d28;
  logic          ov4, ol4, ov28, ol28;
  logic [WW-1:0] w4, w28;

  typedef struct {
    logic [WW-1:0] w;
    logic          last;
    int            idx;
  } cap_t;

  cap_t    caps[$];
  int      checks = 0;
  int      errors = 0;
  int      bad_gap = 0;
  int      stray_last = 0;
  logic [DW-1:0] img [784];

  always #5 clk = ~clk;

  window_gen_3x3 #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v4),
    .in_data   (d4),
    .out_valid (ov4),
    .window    (w4),
    .out_last  (ol4)
  );

  window_gen_3x3 #(.DATA_W(DW), .IMG_W(28), .IMG_H(28)) dut28 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v28),
    .in_data   (d28),
    .out_valid (ov28),
    .window    (w28),
    .out_last  (ol28)
  );

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, let the edge pass, sample outputs 1 ns later.
  task automatic step(input bit big, input bit v, input logic [DW-1:0] d, input int idx);
    logic          ov, ol;
    logic [WW-1:0] w;
    cap_t          c;
    if (big) begin v28 = v; d28 = d; end
    else     begin v4  = v; d4  = d; end
    @(posedge clk);
    #1;
    ov = big ? ov28 : ov4;
    ol = big ? ol28 : ol4;
    w  = big ? w28  : w4;
    if (ov) begin
      c.w    = w;
      c.last = ol;
      c.idx  = v ? idx : -1;
      caps.push_back(c);
      $display("window %s after pixel %0d last=%0b data=%h", big ? "28x28" : "4x4", c.idx, ol, w);
    end
    if (!v && ov) bad_gap++;
    if (ol && !ov) stray_last++;
  endtask

  function automatic logic [DW-1:0] pix4(input int r, input int c, input int base);
    return DW'(base + 16 * r + c);
  endfunction

  function automatic logic [WW-1:0] exp4(input int r, input int c, input int base);
    logic [WW-1:0] e;
    e = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        e[DW*(3*dr+dc) +: DW] = pix4(r - 2 + dr, c - 2 + dc, base);
    return e;
  endfunction

  task automatic frame4(input int base, input bit gapped);
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b1, pix4(k / 4, k % 4, base), k);
      if (gapped) step(1'b0, 1'b0, '0, -1);
    end
  endtask

  // Compare captured 4x4 windows against nframes frames with the given bases.
  task automatic check4(input string tag, input int nframes, input int base0, input int base1);
    int f, m, r, c, base;
    chk($sformatf("%s count", tag), WW'(caps.size()), WW'(4 * nframes));
    for (int j = 0; j < caps.size() && j < 4 * nframes; j++) begin
      f = j / 4;
      m = j % 4;
      r = 2 + m / 2;
      c = 2 + m % 2;
      base = (f == 0) ? base0 : base1;
      chk($sformatf("%s w%0d idx", tag, j), WW'(caps[j].idx), WW'(4 * r + c));
      chk($sformatf("%s w%0d data", tag, j), caps[j].w, exp4(r, c, base));
      chk($sformatf("%s w%0d last", tag, j), WW'(caps[j].last), WW'(m == 3));
    end
    caps.delete();
  endtask

  initial begin
    int r, c;
    logic [WW-1:0] e;

    rst = 1'b1;
    v4 = 1'b0; v28 = 1'b0; d4 = '0; d28 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid4", WW'(ov4), '0);
    chk("reset out_last4", WW'(ol4), '0);
    chk("reset window4", w4, '0);
    chk("reset out_valid28", WW'(ov28), '0);
    chk("reset window28", w28, '0);
    rst = 1'b0;

    // Continuous frame; windows only after pixels 10, 11, 14, 15.
    frame4(0, 1'b0);
    check4("cont", 1, 0, 0);

    // Gapped input: same windows, never after an idle cycle.
    bad_gap = 0;
    frame4(0, 1'b1);
    check4("gap", 1, 0, 0);
    chk("gap no out after idle", WW'(bad_gap), '0);

    // Two frames back-to-back, second offset by 0x100.
    frame4(0, 1'b0);
    frame4(256, 1'b0);
    check4("b2b", 2, 0, 256);

    // Reset after 6 pixels, then a clean frame.
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, pix4(k / 4, k % 4, 0), k);
    chk("mid partial count", WW'(caps.size()), '0);
    rst = 1'b1;
    v4 = 1'b0;
    @(posedge clk);
    #1;
    chk("mid rst out_valid", WW'(ov4), '0);
    chk("mid rst out_last", WW'(ol4), '0);
    chk("mid rst window", w4, '0);
    rst = 1'b0;
    step(1'b0, 1'b0, '0, -1);
    chk("mid post out_valid", WW'(ov4), '0);
    chk("mid post window", w4, '0);
    frame4(0, 1'b0);
    check4("mid", 1, 0, 0);

    // Full-size frame with random pixels.
    for (int k = 0; k < 784; k++) img[k] = DW'($urandom);
    for (int k = 0; k < 784; k++) step(1'b1, 1'b1, img[k], k);
    step(1'b1, 1'b0, '0, -1);
    chk("big count", WW'(caps.size()), WW'(676));
    for (int j = 0; j < caps.size() && j < 676; j++) begin
      r = 2 + j / 26;
      c = 2 + j % 26;
      e = '0;
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          e[DW*(3*dr+dc) +: DW] = img[28 * (r - 2 + dr) + (c - 2 + dc)];
      chk($sformatf("big w%0d idx", j), WW'(caps[j].idx), WW'(28 * r + c));
      chk($sformatf("big w%0d data", j), caps[j].w, e);
      chk($sformatf("big w%0d last", j), WW'(caps[j].last), WW'(j == 675));
    end
    caps.delete();

    chk("no out_last without out_valid", WW'(stray_last), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3×3 sliding-window generator for the CNN datapath. It accepts one raster-order pixel per cycle and buffers the two previous image rows in line FIFOs. Each time a complete 3×3 neighbourhood is available, it emits the 9 pixels as one packed 144-bit word. It sits directly upstream of the 3×3 multiply/adder-tree convolution stage, and its `window` output feeds that stage's `x` input bit-for-bit.

## Interface
Parameters:
- `DATA_W`, 16, pixel width in bits.
- `IMG_W`, 28, image width in pixels (≥3).
- `IMG_H`, 28, image height in pixels (≥3).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  pixel present on `in_data` this cycle.
- `in_data`  in  DATA_W  pixel, raster order: row-major, left to right.
- `out_valid`  out  1  `window` holds a new complete window this cycle.
- `window`  out  9*DATA_W  element i at `[DATA_W*(i+1)-1 : DATA_W*i]`, with i = 3*row + col. Row 0 is the oldest row and col 0 the leftmost column, so i=0 is the top-left pixel and i=8 is the current pixel.
- `out_last`  out  1  asserted together with `out_valid` on the final window of a frame.

## Operation
- There is no backpressure. The downstream stage is fully pipelined and always accepts.
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on `in_valid`.
  - `col` wraps to 0 at IMG_W-1 and increments `row`.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0, and the next pixel starts a new frame.
- Line FIFOs:
  - `lf1` holds the previous row and `lf0` the row before it.
  - On each accepted pixel: `lf1` pops into `lf0`'s push, and `in_data` is pushed into `lf1`. Both are depth IMG_W and shift only on `in_valid`.
- Window shift register: 3 rows × 3 columns.
  - On `in_valid`, each row shifts left one column.
  - The new column is {lf0 out, lf1 out, in_data}, written into rows 0, 1 and 2 respectively.
- Window emission and padding:
  - A window is emitted for the accepted pixel at (r,c) only when r≥2 and c≥2. This is valid convolution with no padding.
  - Windows that straddle a row boundary are suppressed.
  - Output count per frame is (IMG_H-2)*(IMG_W-2).
- Arithmetic: none. Pixels pass through unchanged; no sign or width conversion.
- Reset:
  - `out_valid`, `out_last` and `window` go to 0.
  - `col` and `row` go to 0.
  - Line FIFO contents are not cleared; the row gating makes stale data unobservable.
  - Reset mid-frame discards the partial frame. The next accepted pixel is treated as (0,0).

## Timing
- Latency: the pixel accepted at cycle t with (r≥2, c≥2) produces `out_valid`=1 at cycle t+1, with `window` = pixels rows r-2..r, cols c-2..c.
- `out_valid`, `out_last` and `window` are all registered outputs.
- `in_valid`=0 at cycle t gives `out_valid`=0 at t+1. `window` holds its last value, and no internal state moves.
- `out_last` is 1 only at t+1 after accepting pixel (IMG_H-1, IMG_W-1).
- Back-to-back frames: the first pixel of frame N+1 may arrive in the cycle after the last pixel of frame N. No bubble is required, and no window mixes the two frames.
- Throughput: 1 pixel/cycle sustained.

## Structure
- Shared package `cnn_pkg`:
  - `DATA_W`=16, `KSIZE`=3, `WIN_W`=DATA_W*KSIZE*KSIZE.
  - The window element-index convention (i = 3*row + col), shared with the convolution stage.
- Sub-module `line_fifo` (params WIDTH, DEPTH; ports `clk`, `rst`, `en`, `din`, `dout`):
  - Implemented as an enable-gated circular RAM with a single wrap pointer.
  - Instantiated twice with DEPTH=IMG_W.
- Top level contains the counters, the 3×3 register array and the output registers.

## Test plan
For all scenarios, IMG_W=IMG_H=4 unless stated. Each pixel value is 16*r + c.
- Continuous frame: feed 16 pixels back-to-back.
  - Exactly 4 windows, one cycle after pixels (2,2), (2,3), (3,2), (3,3).
  - First window elements i=0..8 = 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22.
  - `out_last` only on the 4th window, whose elements = 0x11,0x12,0x13,0x21,0x22,0x23,0x31,0x32,0x33.
- Gapped input: `in_valid` alternating 1/0.
  - Same 4 windows with identical contents.
  - `out_valid` never asserts in a cycle that follows `in_valid`=0.
- Row boundary: check that no window is emitted after pixels (2,0), (2,1), (3,0), (3,1).
- Two frames back-to-back, with frame 2 values = value + 0x100.
  - 8 windows total.
  - First window of frame 2 = 0x100,0x101,0x102,0x110,…,0x122, with no frame-1 data.
- Reset mid-frame: pulse `rst` after 6 pixels, then send a full frame.
  - Outputs are 0 during and after the reset cycle.
  - Results then match the continuous-frame scenario exactly.
- Default size IMG_W=IMG_H=28, random data, continuous input: 676 windows, each matching a software 3×3 extraction reference.
